// File: rtl/shake128_absorb_stream.sv
// SHAKE128 absorb front end: XORs 64-bit little-endian beats into the rate lanes,
// hands full blocks to an external Keccak-f[1600] core and applies SHAKE padding.
module shake128_absorb_stream #(
    parameter int unsigned RATE = 168,
    parameter logic [7:0]  DSEP = 8'h1F
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    input  logic [3:0]    in_bytes,
    output logic          perm_start,
    output logic [1599:0] perm_state_out,
    input  logic [1599:0] perm_state_in,
    input  logic          perm_done,
    output logic [1599:0] state_s_out,
    output logic          done
);

    localparam int unsigned L   = RATE / 8;
    localparam int unsigned PSW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned BW  = $clog2(RATE + 1);

    typedef enum logic [2:0] {IDLE, ABSORB, PERM, PAD, DONE} state_e;

    state_e          fsm_q, fsm_d;
    logic [1599:0]   st_q, st_d;
    logic [PSW-1:0]  pos_q, pos_d;
    logic [BW-1:0]   pad_q, pad_d;
    logic            pend_q, pend_d;
    logic            first_q, first_d;

    logic [3:0]      nbytes;
    logic [63:0]     beat;
    logic [BW-1:0]   pad_idx;

    // Last-beat byte count (clamped to 8), masked beat and resulting pad byte index.
    always_comb begin
        nbytes = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        beat   = in_data;
        if (in_last) begin
            for (int unsigned j = 0; j < 8; j++) begin
                if (4'(j) >= nbytes) beat[8*j +: 8] = '0;
            end
        end
        pad_idx = BW'({pos_q, 3'b000}) + BW'(nbytes);
    end

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        pos_d   = pos_q;
        pad_d   = pad_q;
        pend_d  = pend_q;
        first_d = 1'b0;

        if (start) begin
            fsm_d  = ABSORB;
            st_d   = '0;
            pos_d  = '0;
            pad_d  = '0;
            pend_d = 1'b0;
        end else begin
            case (fsm_q)
                ABSORB: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < L; i++) begin
                            if (pos_q == PSW'(i)) st_d[64*i +: 64] = st_q[64*i +: 64] ^ beat;
                        end
                        if (!in_last) begin
                            if (pos_q == PSW'(L - 1)) begin
                                pos_d   = '0;
                                fsm_d   = PERM;
                                first_d = 1'b1;
                            end else begin
                                pos_d = pos_q + PSW'(1);
                            end
                        end else if (pad_idx == BW'(RATE)) begin
                            // Message ends exactly on a block boundary: permute, then pad at byte 0.
                            pend_d  = 1'b1;
                            pad_d   = '0;
                            pos_d   = '0;
                            fsm_d   = PERM;
                            first_d = 1'b1;
                        end else begin
                            pad_d = pad_idx;
                            fsm_d = PAD;
                        end
                    end
                end
                PERM: begin
                    if (!first_q && perm_done) begin
                        st_d   = perm_state_in;
                        fsm_d  = pend_q ? PAD : ABSORB;
                        pend_d = 1'b0;
                    end
                end
                PAD: begin
                    for (int unsigned j = 0; j < RATE; j++) begin
                        if (pad_q == BW'(j)) st_d[8*j +: 8] = st_q[8*j +: 8] ^ DSEP;
                    end
                    st_d[8*(RATE-1) +: 8] = st_d[8*(RATE-1) +: 8] ^ 8'h80;
                    fsm_d = DONE;
                end
                default: ;
            endcase
        end

        in_ready   = (fsm_q == ABSORB);
        perm_start = (fsm_q == PERM) && first_q;
        done       = (fsm_q == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q   <= IDLE;
            st_q    <= '0;
            pos_q   <= '0;
            pad_q   <= '0;
            pend_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            pos_q   <= pos_d;
            pad_q   <= pad_d;
            pend_q  <= pend_d;
            first_q <= first_d;
        end
    end

    assign perm_state_out = st_q;
    assign state_s_out    = st_q;

endmodule

// File: tb/tb_shake128_absorb_stream.sv
// Randomized scoreboard bench for shake128_absorb_stream with a byte-level SHAKE
// absorb model and a stub permutation core (byte rotate + invert).
module tb_shake128_absorb_stream;

    localparam int unsigned RATE = 168;
    localparam logic [7:0]  DSEP = 8'h1F;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic [3:0]    in_bytes = '0;
    logic          perm_start;
    logic [1599:0] perm_state_out;
    logic [1599:0] perm_state_in = '0;
    logic          perm_done = 1'b0;
    logic [1599:0] state_s_out;
    logic          done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1599:0] st;
        int            nperm;
    } exp_t;

    exp_t          expq[$];
    exp_t          mon_e;
    logic [1599:0] exp_last;
    logic [1599:0] cap_state;
    int            perm_delay = 3;
    int            pcnt = 0;
    bit            in_perm = 1'b0;
    bit            done_prev = 1'b0;

    always #5 clock = ~clock;

    shake128_absorb_stream #(.RATE(RATE), .DSEP(DSEP)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes),
        .perm_start(perm_start), .perm_state_out(perm_state_out),
        .perm_state_in(perm_state_in), .perm_done(perm_done),
        .state_s_out(state_s_out), .done(done)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_state(input string name, input logic [1599:0] act, input logic [1599:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            for (int i = 0; i < 25; i++) begin
                if (act[64*i +: 64] !== req[64*i +: 64]) begin
                    $display("FAIL %s lane %0d actual=%h required=%h", name, i, act[64*i +: 64], req[64*i +: 64]);
                    break;
                end
            end
        end
    endtask

    // SHAKE absorb+finalize over a byte array; permutes every time RATE bytes accumulate.
    function automatic logic [1599:0] model(input logic [7:0] m[$], output int np);
        logic [7:0]    s[200];
        logic [7:0]    t[200];
        logic [1599:0] r;
        int            off = 0;
        np = 0;
        for (int k = 0; k < 200; k++) s[k] = 8'h00;
        for (int i = 0; i < m.size(); i++) begin
            s[off] = s[off] ^ m[i];
            off++;
            if (off == int'(RATE)) begin
                for (int k = 0; k < 200; k++) t[k] = ~s[(k + 1) % 200];
                s = t;
                np++;
                off = 0;
            end
        end
        s[off] = s[off] ^ DSEP;
        s[RATE-1] = s[RATE-1] ^ 8'h80;
        for (int k = 0; k < 200; k++) r[8*k +: 8] = s[k];
        return r;
    endfunction

    // Stub permutation core: new byte i = ~old byte (i+1) mod 200.
    always begin
        @(negedge clock);
        if (reset && perm_start) begin
            cap_state = perm_state_out;
            repeat (perm_delay) @(posedge clock);
            #1;
            perm_state_in = ~{cap_state[7:0], cap_state[1599:8]};
            perm_done = 1'b1;
            @(posedge clock);
            #1;
            perm_done = 1'b0;
            perm_state_in = '0;
        end
    end

    // Monitor: pops the scoreboard on each rising done and polices in_ready during PERM.
    always @(negedge clock) begin
        if (!reset || start) begin
            pcnt = 0;
            in_perm = 1'b0;
        end else begin
            if (perm_start) begin
                pcnt++;
                in_perm = 1'b1;
            end
            if (in_perm) chk("in_ready_in_perm", int'(in_ready), 0);
            if (perm_done) in_perm = 1'b0;
            if (done && !done_prev) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    mon_e = expq.pop_front();
                    chk_state("final_state", state_s_out, mon_e.st);
                    chk("perm_count", pcnt, mon_e.nperm);
                end
            end
        end
        done_prev = done;
    end

    task automatic send_msg(input logic [7:0] m[$], input bit gapless, input bit restart);
        logic [63:0] bd[$];
        bit          bl[$];
        logic [3:0]  bn[$];
        exp_t        e;
        logic [63:0] w;
        int          len = m.size();
        int          idx = 0;
        int          i = 0;
        int          cyc = 0;
        int          stalls = 0;
        int          nonlast;
        int          nl;
        bit          acc;
        bit          wrap;
        bit          full_last;

        full_last = (len % 8 == 0) && (len > 0) && ($urandom_range(0, 1) == 1);
        nonlast   = full_last ? len / 8 - 1 : len / 8;
        for (int b = 0; b < nonlast; b++) begin
            w = '0;
            for (int j = 0; j < 8; j++) begin
                w[8*j +: 8] = m[idx];
                idx++;
            end
            bd.push_back(w); bl.push_back(1'b0); bn.push_back(4'd8);
        end
        w  = {$urandom, $urandom};
        nl = len - idx;
        for (int j = 0; j < nl; j++) begin
            w[8*j +: 8] = m[idx];
            idx++;
        end
        bd.push_back(w); bl.push_back(1'b1);
        bn.push_back((nl == 8) ? 4'($urandom_range(8, 15)) : 4'(nl));

        e.st = model(m, e.nperm);
        exp_last = e.st;
        expq.push_back(e);
        wrap = (len > 0) && (len % int'(RATE) == 0);

        if (restart) begin
            @(posedge clock); #1;
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            in_valid = 1'b1; in_data = {$urandom, $urandom}; in_last = 1'b0;
            repeat (2) begin
                @(posedge clock); #1;
            end
        end
        @(posedge clock); #1;
        start = 1'b1;
        in_valid = restart; in_data = bd[0]; in_last = bl[0]; in_bytes = bn[0];
        @(posedge clock); #1;
        start = 1'b0;

        while (i < bd.size() && cyc < 5000) begin
            in_valid = gapless || ($urandom_range(0, 3) != 0);
            in_data = bd[i]; in_last = bl[i]; in_bytes = bn[i];
            acc = in_valid && in_ready;
            if (gapless && !acc) stalls++;
            @(posedge clock); #1;
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (i < bd.size()) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout actual=%0d required=%0d", i, bd.size());
            void'(expq.pop_back());
            return;
        end
        if (gapless) chk("stall_cycles", stalls, 0);
        if (!wrap) begin
            chk("done_right_after_last_beat", int'(done), 0);
            @(posedge clock); #1;
            chk("done_two_edges_after_beat", int'(done), 1);
        end else begin
            cyc = 0;
            while (!done && cyc < 200) begin
                @(posedge clock); #1;
                cyc++;
            end
            chk("done_after_wrap", int'(done), 1);
        end
        in_valid = 1'b1; in_data = {$urandom, $urandom}; in_last = 1'b1; in_bytes = 4'd8;
        repeat (3) begin
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("in_ready_in_done", int'(in_ready), 0);
        chk("done_level_held", int'(done), 1);
        chk_state("state_held_in_done", state_s_out, exp_last);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m[$];

        repeat (3) @(posedge clock);
        #1;
        chk_state("reset_state", state_s_out, '0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_perm_start", int'(perm_start), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b1;

        m.delete();
        send_msg(m, 1'b0, 1'b0);

        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0, 1'b1);

        m.delete();
        for (int k = 0; k < 167; k++) m.push_back(8'($urandom));
        send_msg(m, 1'b1, 1'b0);

        m.delete();
        for (int k = 0; k < 168; k++) m.push_back(8'($urandom));
        send_msg(m, 1'b0, 1'b0);

        perm_delay = 24;
        m.delete();
        for (int k = 0; k < 34; k++) m.push_back(8'($urandom));
        send_msg(m, 1'b0, 1'b0);
        m.delete();
        for (int k = 0; k < 400; k++) m.push_back(8'($urandom));
        send_msg(m, 1'b0, 1'b0);

        // Abandon a permutation with an asynchronous reset; its late perm_done must not land.
        perm_delay = 10;
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        in_valid = 1'b1; in_last = 1'b0;
        for (int b = 0; b < int'(RATE / 8); b++) begin
            in_data = {$urandom, $urandom};
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk_state("async_reset_state", state_s_out, '0);
        chk("async_reset_perm_start", int'(perm_start), 0);
        chk("async_reset_in_ready", int'(in_ready), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (15) begin
            @(posedge clock); #1;
        end
        chk_state("stale_perm_done_ignored", state_s_out, '0);
        chk("stale_done_low", int'(done), 0);

        perm_delay = 2;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            perm_delay = $urandom_range(1, 24);
            m.delete();
            for (int k = 0; k < int'($urandom_range(0, 420)); k++) m.push_back(8'($urandom));
            send_msg(m, 1'b0, ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(posedge clock);
        #1;
        chk("scoreboard_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
